if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch front end of the MIPS32 pipeline.
- Owns the program counter and drives the instruction ROM address and chip-enable.
- Captures the ROM's combinational instruction output into the IF/ID pipeline register consumed by decode.
- Handles sequential increment, branch redirect, pipeline stall, and flush (exception/eret redirect).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- stall_if_i  in  1  hold PC; IF produces no new instruction this cycle.
- stall_id_i  in  1  hold the IF/ID register contents.
- flush_i  in  1  discard IF/ID contents and redirect the PC to flush_pc_i.
- flush_pc_i  in  32  redirect target on flush.
- branch_flag_i  in  1  single-cycle pulse from decode: take branch.
- branch_target_i  in  32  branch/jump destination.
- inst_i  in  32  instruction from ROM; combinational in pc_o.
- pc_o  out  32  fetch address to ROM.
- ce_o  out  1  ROM chip enable.
- id_pc_o  out  32  PC of the instruction held in IF/ID.
- id_inst_o  out  32  instruction held in IF/ID.
- id_valid_o  out  1  IF/ID holds a real instruction, not a bubble.

Behaviour:
- Reset values:
  - pc_o = RESET_PC, ce_o = 0.
  - id_pc_o = 0, id_inst_o = NOP_INST, id_valid_o = 0.
  - Pending-branch register cleared.
- ce_o rises on the first clock edge after rst deasserts. The first fetch is RESET_PC, with pc_o unchanged on that edge.
- PC update each edge while ce_o = 1, in priority order:
  1. rst
  2. flush_i: pc ← flush_pc_i; clear pending branch.
  3. stall_if_i: pc holds. If branch_flag_i = 1, latch branch_target_i into the pending register, with pending valid = 1.
  4. Pending valid: pc ← pending target; clear pending.
  5. branch_flag_i: pc ← branch_target_i.
  6. Otherwise: pc ← pc + 4.
- A branch is never lost across a stall. A second branch_flag_i arriving while one is already pending overwrites the pending target; the newest branch wins.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no error flagged.
- Branch and flush targets have bits [1:0] forced to 00; see the optional feature for misalignment checking.
- IF/ID register, updated each edge:
  - rst or flush_i: NOP_INST, valid 0, id_pc_o 0.
  - Else if stall_id_i: hold all three outputs.
  - Else if stall_if_i: insert bubble (NOP_INST, valid 0, id_pc_o unchanged).
  - Else: capture pc_o, inst_i, and valid = ce_o.
- Latency: an instruction at address A appears on id_inst_o one edge after pc_o = A with no stall. Taken-branch redirect costs one delay-slot instruction, which is the instruction fetched in the same cycle as branch_flag_i; it enters IF/ID normally and is not squashed.
- flush_i coinciding with stall_if_i or stall_id_i: flush wins for both PC and IF/ID.
- With ce_o = 0, pc_o stays at RESET_PC and IF/ID stays a bubble.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output id_adel_o (1 bit), with reset value 0.
  - When a branch or flush target has bits [1:0] ≠ 00, the PC loads the raw unaligned value.
  - The instruction captured from that PC enters IF/ID as NOP_INST, with id_valid_o = 1 and id_adel_o = 1, so the exception unit can raise AdEL.
  - id_adel_o follows the same hold, bubble, and flush rules as id_valid_o.
- Undefined:
  - Port absent.
  - Target bits [1:0] are silently forced to 00 as stated above.

Decomposition:
- Shared package cpu_defs_pkg:
  - INST_WIDTH = 32, ADDR_WIDTH = 32.
  - RESET_PC default, NOP_INST constant.
  - Typedef if_id_t {pc, inst, valid[, adel]}.
- Sub-module if_id_reg: the IF/ID register with hold, bubble, and flush controls, reusable for other inter-stage registers.
- PC and pending-branch logic stay in the top level.

Test Plan:
- Reset, then straight-line fetch: rst held for 2 cycles, then released; ROM word n = 32'h1000_0000 + n.
  - pc_o sequence: 0, 0, 4, 8, C.
  - id_inst_o: 32'h1000_0000 valid one edge after the first fetch, then successive words.
- Branch: branch_flag_i pulse with target 32'h40 while pc_o = 8.
  - Delay-slot instruction at 8 enters IF/ID.
  - Next pc_o = 32'h40; no skipped or duplicated instruction.
- Branch during stall: stall_if_i = 1 for 3 cycles, with branch_flag_i pulsed (target 32'h80) in the first stall cycle.
  - pc_o holds; IF/ID shows bubbles (id_valid_o = 0).
  - After the stall releases, pc_o = 32'h80.
- Flush versus stall: flush_i = 1, flush_pc_i = 32'h180, with stall_id_i = 1 and stall_if_i = 1 in the same cycle.
  - Next edge: pc_o = 32'h180, id_valid_o = 0, id_inst_o = NOP_INST.
- Wrap-around: force pc_o to 32'hFFFF_FFFC via flush.
  - Next pc_o = 32'h0000_0000.
  - id_pc_o then reads FFFF_FFFC, followed by 0.
- IF_ALIGN_CHECK_EN: branch target 32'h42.
  - pc_o = 32'h42.
  - Next edge: id_adel_o = 1, id_valid_o = 1, id_inst_o = NOP_INST.
  - Without the macro: pc_o = 32'h40.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared MIPS32 pipeline widths, reset constants and the IF/ID record.
// IF_ALIGN_CHECK_EN adds the adel flag to the IF/ID record.
package cpu_defs_pkg;
    localparam int INST_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0000;
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
        logic valid;
`ifdef IF_ALIGN_CHECK_EN
        logic adel;
`endif
    } if_id_t;
endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// if_id_reg: inter-stage register with flush, hold and bubble-insert controls.
// IF_ALIGN_CHECK_EN carries the adel flag under the same rules as valid.
module if_id_reg
    import cpu_defs_pkg::*;
#(
    parameter logic [INST_WIDTH-1:0] BUBBLE_INST = NOP_INST
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   hold,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            q.pc <= '0;
            q.inst <= BUBBLE_INST;
            q.valid <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
            q.adel <= 1'b0;
`endif
        end else if (!hold) begin
            if (!bubble) q.pc <= d.pc;
            q.inst <= bubble ? BUBBLE_INST : d.inst;
            q.valid <= !bubble && d.valid;
`ifdef IF_ALIGN_CHECK_EN
            q.adel <= !bubble && d.adel;
`endif
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS32 fetch front end - PC, pending branch across stalls, IF/ID capture.
// IF_ALIGN_CHECK_EN keeps unaligned targets raw and flags them on id_adel_o.
module if_fetch_stage #(
    parameter logic [cpu_defs_pkg::ADDR_WIDTH-1:0] RESET_PC = cpu_defs_pkg::RESET_PC,
    parameter logic [cpu_defs_pkg::INST_WIDTH-1:0] NOP_INST = cpu_defs_pkg::NOP_INST
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  stall_if_i,
    input  logic                                  stall_id_i,
    input  logic                                  flush_i,
    input  logic [cpu_defs_pkg::ADDR_WIDTH-1:0]   flush_pc_i,
    input  logic                                  branch_flag_i,
    input  logic [cpu_defs_pkg::ADDR_WIDTH-1:0]   branch_target_i,
    input  logic [cpu_defs_pkg::INST_WIDTH-1:0]   inst_i,
    output logic [cpu_defs_pkg::ADDR_WIDTH-1:0]   pc_o,
    output logic                                  ce_o,
    output logic [cpu_defs_pkg::ADDR_WIDTH-1:0]   id_pc_o,
    output logic [cpu_defs_pkg::INST_WIDTH-1:0]   id_inst_o,
    output logic                                  id_valid_o
`ifdef IF_ALIGN_CHECK_EN
    ,
    output logic                                  id_adel_o
`endif
);
    import cpu_defs_pkg::if_id_t;
    logic ce;
    logic pend_v;
    logic [31:0] pc;
    logic [31:0] pend_t;
    logic [31:0] br_t;
    logic [31:0] fl_t;
    if_id_t d;
    if_id_t q;
`ifdef IF_ALIGN_CHECK_EN
    assign br_t = branch_target_i;
    assign fl_t = flush_pc_i;
`else
    assign br_t = branch_target_i & ~32'h3;
    assign fl_t = flush_pc_i & ~32'h3;
`endif
    // a branch seen during an IF stall is parked until the stall releases; newest wins
    always_ff @(posedge clk) begin
        ce <= !rst;
        if (rst) begin
            pc <= RESET_PC;
            pend_v <= 1'b0;
            pend_t <= '0;
        end else if (ce) begin
            if (flush_i) begin
                pc <= fl_t;
                pend_v <= 1'b0;
            end else if (stall_if_i) begin
                if (branch_flag_i) begin
                    pend_v <= 1'b1;
                    pend_t <= br_t;
                end
            end else if (pend_v) begin
                pc <= pend_t;
                pend_v <= 1'b0;
            end else begin
                pc <= branch_flag_i ? br_t : pc + 32'd4;
            end
        end
    end
    always_comb begin
        d.pc = pc;
        d.valid = ce;
`ifdef IF_ALIGN_CHECK_EN
        d.adel = ce && pc[1:0] != 2'b00;
        d.inst = ce && !d.adel ? inst_i : NOP_INST;
`else
        d.inst = ce ? inst_i : NOP_INST;
`endif
    end
    if_id_reg #(.BUBBLE_INST(NOP_INST)) u_if_id (
        .clk(clk),
        .rst(rst),
        .flush(flush_i),
        .hold(stall_id_i),
        .bubble(stall_if_i),
        .d(d),
        .q(q)
    );
    assign pc_o = pc;
    assign ce_o = ce;
    assign id_pc_o = q.pc;
    assign id_inst_o = q.inst;
    assign id_valid_o = q.valid;
`ifdef IF_ALIGN_CHECK_EN
    assign id_adel_o = q.adel;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed vector table for the fetch stage, then random stimulus vs a reference model.
// Honours IF_ALIGN_CHECK_EN the same way the design does.
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst, stall_if_i, stall_id_i, flush_i, branch_flag_i;
    logic [31:0] flush_pc_i, branch_target_i, inst_i;
    logic [31:0] pc_o, id_pc_o, id_inst_o;
    logic ce_o, id_valid_o, adel;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign inst_i = rom(pc_o);

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .stall_if_i(stall_if_i), .stall_id_i(stall_id_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .inst_i(inst_i), .pc_o(pc_o), .ce_o(ce_o),
        .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
`ifdef IF_ALIGN_CHECK_EN
        , .id_adel_o(adel)
`endif
    );
`ifndef IF_ALIGN_CHECK_EN
    assign adel = 1'b0;
`endif

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    endtask

    typedef struct {
        logic rst, sif, sid, fl;
        logic [31:0] fpc;
        logic br;
        logic [31:0] bt, pc;
        logic ce;
        logic [31:0] ipc, iinst;
        logic iv, ia;
    } vec_t;

    function automatic vec_t v(input logic r, sif, sid, fl, input logic [31:0] fpc, input logic br,
                               input logic [31:0] bt, pc, input logic ce, input logic [31:0] ipc, iinst,
                               input logic iv, ia);
        vec_t x;
        x.rst = r; x.sif = sif; x.sid = sid; x.fl = fl; x.fpc = fpc; x.br = br; x.bt = bt;
        x.pc = pc; x.ce = ce; x.ipc = ipc; x.iinst = iinst; x.iv = iv; x.ia = ia;
        return x;
    endfunction

    task automatic drive(input logic r, sif, sid, fl, input logic [31:0] fpc, input logic br, input logic [31:0] bt);
        rst = r; stall_if_i = sif; stall_id_i = sid; flush_i = fl;
        flush_pc_i = fpc; branch_flag_i = br; branch_target_i = bt;
    endtask

    // reference model state
    logic m_ce, m_iv, m_ia;
    logic [31:0] m_pc, m_ipc, m_iinst;
    logic [31:0] pend_q[$];

    function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef IF_ALIGN_CHECK_EN
        return t;
`else
        return t - (t % 4);
`endif
    endfunction

    task automatic model_step;
        logic [31:0] npc;
        logic misal;
        if (rst) begin
            m_ce = 0; m_pc = 32'h0; pend_q.delete();
            m_ipc = 0; m_iinst = 0; m_iv = 0; m_ia = 0;
            return;
        end
        npc = m_pc;
        if (m_ce) begin
            if (flush_i) begin npc = fix(flush_pc_i); pend_q.delete(); end
            else if (stall_if_i) begin
                if (branch_flag_i) begin pend_q.delete(); pend_q.push_back(fix(branch_target_i)); end
            end else if (pend_q.size() > 0) npc = pend_q.pop_front();
            else if (branch_flag_i) npc = fix(branch_target_i);
            else npc = m_pc + 4;
        end
        misal = (m_pc % 4) != 0;
        if (flush_i) begin m_ipc = 0; m_iinst = 0; m_iv = 0; m_ia = 0; end
        else if (stall_id_i) ;
        else if (stall_if_i) begin m_iinst = 0; m_iv = 0; m_ia = 0; end
        else begin
            m_ipc = m_pc;
            m_iv = m_ce;
            m_ia = m_ce && misal;
            m_iinst = (m_ce && !misal) ? rom(m_pc) : 32'h0;
        end
        m_pc = npc;
        m_ce = 1;
    endtask

    vec_t tbl[25];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        //            rst sif sid fl fpc          br bt        pc           ce ipc          iinst         iv ia
        tbl[0]  = v(1, 0, 0, 0, 0,            0, 0,        32'h0,        0, 32'h0,        32'h0,        0, 0);
        tbl[1]  = v(1, 0, 0, 0, 0,            0, 0,        32'h0,        0, 32'h0,        32'h0,        0, 0);
        tbl[2]  = v(0, 0, 0, 0, 0,            0, 0,        32'h0,        1, 32'h0,        32'h0,        0, 0);
        tbl[3]  = v(0, 0, 0, 0, 0,            0, 0,        32'h4,        1, 32'h0,        32'h1000_0000, 1, 0);
        tbl[4]  = v(0, 0, 0, 0, 0,            0, 0,        32'h8,        1, 32'h4,        32'h1000_0001, 1, 0);
        tbl[5]  = v(0, 0, 0, 0, 0,            1, 32'h40,   32'h40,       1, 32'h8,        32'h1000_0002, 1, 0);
        tbl[6]  = v(0, 0, 0, 0, 0,            0, 0,        32'h44,       1, 32'h40,       32'h1000_0010, 1, 0);
        tbl[7]  = v(0, 1, 0, 0, 0,            1, 32'h80,   32'h44,       1, 32'h40,       32'h0,        0, 0);
        tbl[8]  = v(0, 1, 0, 0, 0,            0, 0,        32'h44,       1, 32'h40,       32'h0,        0, 0);
        tbl[9]  = v(0, 1, 0, 0, 0,            0, 0,        32'h44,       1, 32'h40,       32'h0,        0, 0);
        tbl[10] = v(0, 0, 0, 0, 0,            0, 0,        32'h80,       1, 32'h44,       32'h1000_0011, 1, 0);
        tbl[11] = v(0, 0, 0, 0, 0,            0, 0,        32'h84,       1, 32'h80,       32'h1000_0020, 1, 0);
        tbl[12] = v(0, 1, 1, 1, 32'h180,      0, 0,        32'h180,      1, 32'h0,        32'h0,        0, 0);
        tbl[13] = v(0, 0, 0, 0, 0,            0, 0,        32'h184,      1, 32'h180,      32'h1000_0060, 1, 0);
        tbl[14] = v(0, 1, 1, 0, 0,            0, 0,        32'h184,      1, 32'h180,      32'h1000_0060, 1, 0);
        tbl[15] = v(0, 0, 0, 0, 0,            0, 0,        32'h188,      1, 32'h184,      32'h1000_0061, 1, 0);
        tbl[16] = v(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0,       32'hFFFF_FFFC, 1, 32'h0,       32'h0,        0, 0);
        tbl[17] = v(0, 0, 0, 0, 0,            0, 0,        32'h0,        1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 1, 0);
        tbl[18] = v(0, 0, 0, 0, 0,            0, 0,        32'h4,        1, 32'h0,        32'h1000_0000, 1, 0);
        tbl[19] = v(0, 1, 0, 0, 0,            1, 32'h200,  32'h4,        1, 32'h0,        32'h0,        0, 0);
        tbl[20] = v(0, 1, 0, 0, 0,            1, 32'h300,  32'h4,        1, 32'h0,        32'h0,        0, 0);
        tbl[21] = v(0, 0, 0, 0, 0,            0, 0,        32'h300,      1, 32'h4,        32'h1000_0001, 1, 0);
        tbl[22] = v(0, 0, 0, 0, 0,            0, 0,        32'h304,      1, 32'h300,      32'h1000_00C0, 1, 0);
`ifdef IF_ALIGN_CHECK_EN
        tbl[23] = v(0, 0, 0, 0, 0,            1, 32'h42,   32'h42,       1, 32'h304,      32'h1000_00C1, 1, 0);
        tbl[24] = v(0, 0, 0, 0, 0,            0, 0,        32'h46,       1, 32'h42,       32'h0,        1, 1);
`else
        tbl[23] = v(0, 0, 0, 0, 0,            1, 32'h42,   32'h40,       1, 32'h304,      32'h1000_00C1, 1, 0);
        tbl[24] = v(0, 0, 0, 0, 0,            0, 0,        32'h44,       1, 32'h40,       32'h1000_0010, 1, 0);
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].sif, tbl[i].sid, tbl[i].fl, tbl[i].fpc, tbl[i].br, tbl[i].bt);
            @(posedge clk); #1;
            chk($sformatf("vec%0d pc_o", i), pc_o, tbl[i].pc);
            chk($sformatf("vec%0d ce_o", i), {31'b0, ce_o}, {31'b0, tbl[i].ce});
            chk($sformatf("vec%0d id_pc_o", i), id_pc_o, tbl[i].ipc);
            chk($sformatf("vec%0d id_inst_o", i), id_inst_o, tbl[i].iinst);
            chk($sformatf("vec%0d id_valid_o", i), {31'b0, id_valid_o}, {31'b0, tbl[i].iv});
            chk($sformatf("vec%0d id_adel_o", i), {31'b0, adel}, {31'b0, tbl[i].ia});
        end
        for (int n = 0; n < 3000; n++) begin
            drive(n < 2 || $urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 4095),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4095));
            model_step();
            @(posedge clk); #1;
            chk("rnd pc_o", pc_o, m_pc);
            chk("rnd ce_o", {31'b0, ce_o}, {31'b0, m_ce});
            chk("rnd id_pc_o", id_pc_o, m_ipc);
            chk("rnd id_inst_o", id_inst_o, m_iinst);
            chk("rnd id_valid_o", {31'b0, id_valid_o}, {31'b0, m_iv});
            chk("rnd id_adel_o", {31'b0, adel}, {31'b0, m_ia});
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
